uart_mmio: RTL and testbench
============================

Name: uart_mmio

Overview:
- Memory-mapped UART peripheral that sits directly downstream of the processor's memory port, behind the system address decoder.
- Consumes the processor's address, write-enable, byte-lane mask and lane-shifted write data. Returns zero-wait-state combinational read data.
- Provides a TX FIFO, a single-byte RX holding register, status/error flags and a programmable baud divisor.

Parameters:
- CLK_DIV_DEFAULT, 16'd434: reset value of the baud divisor (clock cycles per bit).
- FIFO_DEPTH_LOG2, 4: TX FIFO depth is 2**FIFO_DEPTH_LOG2 entries of 8 bits.

Ports:
- clk  in  1  system clock
- reset_i  in  1  synchronous, active-low reset; asserted when reset_i==0
- sel_i  in  1  chip select from address decode
- addr_i  in  32  byte address; only [3:2] decoded
- we_i  in  1  write strobe, one cycle per store
- wr_mask_i  in  4  byte-lane write mask, already shifted to lane
- data_i  in  32  write data, already lane-shifted
- data_o  out  32  read data, combinational from addr_i and register state
- uart_rx_i  in  1  serial input, asynchronous
- uart_tx_o  out  1  serial output, idles high
- irq_o  out  1  interrupt; present only with UART_IRQ_EN

Behaviour:
- Register map, selected by addr_i[3:2]:
  - 0 DATA
    - Write (lane 0): push data_i[7:0] into the TX FIFO.
    - Read: {23'b0, rx_valid, rx_byte}.
  - 1 STATUS
    - Read: [0] tx_empty, [1] tx_full, [2] tx_busy, [3] rx_valid, [4] rx_overrun, [5] rx_frame_err, [6] tx_overflow, [15:8] FIFO level, rest 0.
    - Write (lane 0): write-1-to-clear for bits 3..6. Clearing bit 3 acknowledges the RX byte.
  - 2 BAUD: 16-bit divisor, R/W. Lanes 0 and 1 are written independently.
  - 3 reserved: reads 0.
- Reads have no side effects, because the processor issues no read strobe. data_o=0 when sel_i=0.
- A write acts only when sel_i && we_i, and only on lanes whose mask bit is set. A write with a mask lacking the needed lane is ignored.
- Reset: uart_tx_o=1, FIFO empty, all flags 0, rx_byte=0, divisor=CLK_DIV_DEFAULT, both FSMs idle, irq_o=0. Reset during a frame aborts it, and the TX line is high on the next cycle.
- Divisor handling:
  - A divisor of 0 is treated as 1.
  - Each bit lasts exactly div cycles.
  - A divisor write mid-frame takes effect at the next bit boundary.
- TX FSM: IDLE -> START -> DATA(x8, LSB first) -> STOP -> IDLE.
  - Leaves IDLE on the cycle after the FIFO is non-empty; pops on that transition.
  - Back-to-back bytes have no idle gap.
  - tx_busy=1 outside IDLE.
- FIFO rules:
  - A push while full drops the byte and sets tx_overflow.
  - A push and a pop in the same cycle both happen, and the level is unchanged.
  - A push into an empty FIFO while the FSM is idle reaches uart_tx_o at the start bit 2 cycles after the write.
- RX path: uart_rx_i passes through a 2-flop synchroniser.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge moves to START.
  - START: after div/2 cycles, if the line is still low go to DATA, otherwise treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits at div intervals.
  - STOP: if the stop bit is 1, load rx_byte and set rx_valid. If rx_valid was already set, overwrite the byte and set rx_overrun. If the stop bit is 0, set rx_frame_err and discard the byte.
- Acknowledge and new-byte collision: an ack in the same cycle as a new-byte load leaves rx_valid=1 with the new byte and no overrun.

Optional Feature:
- Macro UART_IRQ_EN.
- With the macro:
  - irq_o exists; address 3 becomes IRQ_EN (R/W, lane 0, bits [1:0], reset 0).
  - irq_o is registered: (IRQ_EN[0] && rx_valid) || (IRQ_EN[1] && tx_empty && !tx_busy), one cycle after the condition.
- Without the macro: no irq_o port, and address 3 reads 0 and ignores writes.

Decomposition:
- uart_pkg holds:
  - register offsets (REG_DATA, REG_STATUS, REG_BAUD, REG_IRQ_EN);
  - STATUS bit indices;
  - the tx_state_t and rx_state_t enums.
- Sub-module sync_fifo (parameterised width and depth log2; push/pop/full/empty/level) holds the TX FIFO.
- Baud counters live inline.

Test Plan:
- Reset, then set div=4 and write 0x55 to DATA with mask 0001 -> uart_tx_o shows the start bit 2 cycles later, then 1,0,1,0,1,0,1,0, then stop; each bit lasts 4 cycles; tx_busy falls after 40 cycles.
- Write 17 bytes back-to-back with depth 16 and a slow divisor -> the 17th byte is dropped, STATUS[6]=1, level reads 16. Writing STATUS with 0x40 clears the flag.
- Drive 0xA3 serially at div=8 -> DATA reads 0x1A3. Write STATUS with 0x08 -> DATA reads 0x0A3 with rx_valid=0.
- Send 0x11 then 0x22 without ack -> DATA reads 0x122 and STATUS[4]=1. Send a frame with stop bit 0 -> STATUS[5]=1 and the byte is unchanged.
- Drive a 2-cycle low glitch at div=8 -> RX returns to idle with no flags set. Write DATA with mask 0010 -> FIFO unchanged.
- UART_IRQ_EN: IRQ_EN=1, receive one byte -> irq_o=1 one cycle after rx_valid. Ack -> irq_o=0 on the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// STATUS bit positions and the serial FSM state encodings.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_RX_FERR  = 5;
  localparam int ST_TX_OVF   = 6;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Synchronous FIFO holding bytes queued for the UART transmitter.
// Pushes while full are dropped; pops while empty are ignored.
module sync_fifo #(
  parameter int W   = 8,
  parameter int DL2 = 4
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [DL2:0] level_o
);

  localparam logic [DL2:0] DEPTH = {1'b1, {DL2{1'b0}}};

  logic [W-1:0]   mem_q [2**DL2];
  logic [DL2-1:0] wp_q, wp_d;
  logic [DL2-1:0] rp_q, rp_d;
  logic [DL2:0]   lvl_q, lvl_d;
  logic           do_push, do_pop;

  assign full_o  = (lvl_q == DEPTH);
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign data_o  = mem_q[rp_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wp_d  = do_push ? wp_q + 1'b1 : wp_q;
    rp_d  = do_pop ? rp_q + 1'b1 : rp_q;
    lvl_d = lvl_q;
    unique case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: TX FIFO, RX holding register, flags, baud divisor.
// Define UART_IRQ_EN to add the irq_o output and the IRQ_EN register.
module uart_mmio
  import uart_pkg::*;
#(
  parameter logic [15:0] CLK_DIV_DEFAULT = 16'd434,
  parameter int          FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        sel_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  wr_mask_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o
`ifdef UART_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  logic [1:0]  rsel;
  logic        wr, push;
  logic [3:0]  w1c;
  logic [15:0] div_q, div_d, div_e, half_e;
  logic        unused_bits;

  assign rsel = addr_i[3:2];
  assign wr   = sel_i && we_i;
  assign push = wr && (rsel == REG_DATA) && wr_mask_i[0];
  assign w1c  = (wr && rsel == REG_STATUS && wr_mask_i[0]) ? data_i[6:3] : 4'b0;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  always_comb begin
    div_d = div_q;
    if (wr && rsel == REG_BAUD) begin
      if (wr_mask_i[0]) div_d[7:0]  = data_i[7:0];
      if (wr_mask_i[1]) div_d[15:8] = data_i[15:8];
    end
  end

  assign div_e  = eff_div(div_q);
  assign half_e = ((div_e >> 1) == 16'd0) ? 16'd1 : (div_e >> 1);

  logic                     fifo_full, fifo_empty, tx_pop;
  logic [7:0]               fifo_rd;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;

  sync_fifo #(.W(8), .DL2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (data_i[7:0]),
    .pop_i   (tx_pop),
    .data_o  (fifo_rd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  tx_state_t   tx_q, tx_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [2:0]  tbit_q, tbit_d;
  logic [7:0]  tsh_q, tsh_d;
  logic        ttick, tx_busy;

  assign ttick = (tcnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      tx_q   <= TX_IDLE;
      tcnt_q <= '0;
      tbit_q <= '0;
      tsh_q  <= '0;
    end else begin
      tx_q   <= tx_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tsh_q  <= tsh_d;
    end
  end

  // Every bit boundary reloads from the live divisor.
  always_comb begin
    tx_d   = tx_q;
    tcnt_d = ttick ? tcnt_q : tcnt_q - 1'b1;
    tbit_d = tbit_q;
    tsh_d  = tsh_q;
    tx_pop = 1'b0;
    unique case (tx_q)
      TX_IDLE: begin
        tcnt_d = tcnt_q;
        if (!fifo_empty) begin
          tx_pop = 1'b1;
          tx_d   = TX_START;
          tcnt_d = div_e - 1'b1;
          tsh_d  = fifo_rd;
        end
      end
      TX_START: if (ttick) begin
        tx_d   = TX_DATA;
        tcnt_d = div_e - 1'b1;
        tbit_d = '0;
      end
      TX_DATA: if (ttick) begin
        tcnt_d = div_e - 1'b1;
        tsh_d  = tsh_q >> 1;
        tbit_d = tbit_q + 1'b1;
        if (tbit_q == 3'd7) tx_d = TX_STOP;
      end
      TX_STOP: if (ttick) begin
        tcnt_d = div_e - 1'b1;
        if (!fifo_empty) begin
          tx_pop = 1'b1;
          tx_d   = TX_START;
          tsh_d  = fifo_rd;
        end else begin
          tx_d = TX_IDLE;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_busy   = (tx_q != TX_IDLE);
    uart_tx_o = 1'b1;
    if (tx_q == TX_START) uart_tx_o = 1'b0;
    if (tx_q == TX_DATA)  uart_tx_o = tsh_q[0];
  end

  logic        rs1_q, rs2_q, rs3_q;
  rx_state_t   rx_q, rx_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic [2:0]  rbit_q, rbit_d;
  logic [7:0]  rsh_q, rsh_d;
  logic        rtick, rx_load, rx_ferr_set;

  assign rtick = (rcnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      rs1_q  <= 1'b1;
      rs2_q  <= 1'b1;
      rs3_q  <= 1'b1;
      rx_q   <= RX_IDLE;
      rcnt_q <= '0;
      rbit_q <= '0;
      rsh_q  <= '0;
    end else begin
      rs1_q  <= uart_rx_i;
      rs2_q  <= rs1_q;
      rs3_q  <= rs2_q;
      rx_q   <= rx_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q  <= rsh_d;
    end
  end

  always_comb begin
    rx_d   = rx_q;
    rcnt_d = rtick ? rcnt_q : rcnt_q - 1'b1;
    rbit_d = rbit_q;
    rsh_d  = rsh_q;
    unique case (rx_q)
      RX_IDLE: begin
        rcnt_d = rcnt_q;
        if (rs3_q && !rs2_q) begin
          rx_d   = RX_START;
          rcnt_d = half_e - 1'b1;
        end
      end
      RX_START: if (rtick) begin
        rx_d   = rs2_q ? RX_IDLE : RX_DATA;
        rcnt_d = div_e - 1'b1;
        rbit_d = '0;
      end
      RX_DATA: if (rtick) begin
        rcnt_d = div_e - 1'b1;
        rsh_d  = {rs2_q, rsh_q[7:1]};
        rbit_d = rbit_q + 1'b1;
        if (rbit_q == 3'd7) rx_d = RX_STOP;
      end
      RX_STOP: if (rtick) rx_d = RX_IDLE;
      default: rx_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_load     = (rx_q == RX_STOP) && rtick && rs2_q;
    rx_ferr_set = (rx_q == RX_STOP) && rtick && !rs2_q;
  end

  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       rx_ferr_q, rx_ferr_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  // A new byte beats a same-cycle acknowledge and is not an overrun.
  always_comb begin
    rx_valid_d = rx_load | (rx_valid_q & ~w1c[0]);
    rx_byte_d  = rx_load ? rsh_q : rx_byte_q;
    rx_ovr_d   = (rx_load & rx_valid_q & ~w1c[0]) | (rx_ovr_q & ~w1c[1]);
    rx_ferr_d  = rx_ferr_set | (rx_ferr_q & ~w1c[2]);
    tx_ovf_d   = (push & fifo_full) | (tx_ovf_q & ~w1c[3]);
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      div_q      <= CLK_DIV_DEFAULT;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      div_q      <= div_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  logic [31:0] reg3_rd;

`ifdef UART_IRQ_EN
  logic [1:0] irq_en_q, irq_en_d;
  logic       irq_q;

  assign irq_en_d = (wr && rsel == REG_IRQ_EN && wr_mask_i[0]) ?
                    data_i[1:0] : irq_en_q;

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= (irq_en_q[0] && rx_valid_q) ||
                  (irq_en_q[1] && fifo_empty && !tx_busy);
    end
  end

  assign irq_o   = irq_q;
  assign reg3_rd = {30'b0, irq_en_q};
`else
  assign reg3_rd = '0;
`endif

  logic [31:0] status;

  always_comb begin
    status                = '0;
    status[15:8]          = 8'(fifo_level);
    status[ST_TX_EMPTY]   = fifo_empty;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_BUSY]    = tx_busy;
    status[ST_RX_VALID]   = rx_valid_q;
    status[ST_RX_OVR]     = rx_ovr_q;
    status[ST_RX_FERR]    = rx_ferr_q;
    status[ST_TX_OVF]     = tx_ovf_q;
  end

  always_comb begin
    data_o = '0;
    if (sel_i) begin
      unique case (rsel)
        REG_DATA:   data_o = {23'b0, rx_valid_q, rx_byte_q};
        REG_STATUS: data_o = status;
        REG_BAUD:   data_o = {16'b0, div_q};
        default:    data_o = reg3_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register vectors, serial TX/RX
// against a byte-level reference model, FIFO overflow and reset abort.
module tb_uart_mmio;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
`ifdef UART_IRQ_EN
  logic        irq;
`endif

  uart_mmio dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .sel_i     (sel),
    .addr_i    (addr),
    .we_i      (we),
    .wr_mask_i (mask),
    .data_i    (wdata),
    .data_o    (rdata),
    .uart_rx_i (uart_rx),
    .uart_tx_o (uart_tx)
`ifdef UART_IRQ_EN
    ,
    .irq_o     (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // tx_hist[k] is the line state after the k-th rising edge
  logic tx_hist[$];
  always @(posedge clk) begin
    #2;
    tx_hist.push_back(uart_tx);
  end

  logic [7:0] txq[$];

  // RX reference state, kept at the byte/flag level
  logic       m_valid = 0, m_ovr = 0, m_ferr = 0;
  logic [7:0] m_byte = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic s, input logic [1:0] r,
                    input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    sel = s; we = 1'b1; addr = {28'h0, r, 2'b00}; mask = m; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; mask = '0;
  endtask

  task automatic rd(input logic s, input logic [1:0] r,
                    output logic [31:0] v);
    sel = s; we = 1'b0; addr = {28'h0, r, 2'b00};
    #1 v = rdata;
    sel = 1'b0;
  endtask

  task automatic tx_burst(input int d, output int w);
    wr(1, REG_BAUD, 4'b0011, d);
    @(negedge clk);
    w = tx_hist.size();
    for (int i = 0; i < txq.size(); i++) begin
      if (i > 0) @(negedge clk);
      sel = 1; we = 1; addr = {28'h0, REG_DATA, 2'b00};
      mask = 4'b0001; wdata = {24'hABCDEF, txq[i]};
    end
    @(negedge clk);
    sel = 0; we = 0; mask = '0;
  endtask

  task automatic check_tx(input int w, input int d);
    int de, n, tot, guard;
    logic e, bad;
    de = (d == 0) ? 1 : d;
    n = txq.size();
    tot = 10 * n * de;
    guard = 0;
    while (tx_hist.size() < w + tot + 3 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk("tx_timeout", 32'(tx_hist.size() >= w + tot + 3), 32'd1);
    if (tx_hist.size() >= w + tot + 3) begin
      chk("tx_pre_idle", 32'(tx_hist[w]), 32'd1);
      for (int k = 0; k < n; k++)
        for (int b = 0; b < 10; b++) begin
          e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : txq[k][b-1];
          bad = e;
          for (int c = 0; c < de; c++)
            if (tx_hist[w + 1 + (k * 10 + b) * de + c] !== e)
              bad = tx_hist[w + 1 + (k * 10 + b) * de + c];
          chk($sformatf("tx_byte%0d_bit%0d", k, b), 32'(bad), 32'(e));
        end
      chk("tx_post_idle", 32'(tx_hist[w + 1 + tot]), 32'd1);
    end
    txq.delete();
  endtask

  task automatic frame(input logic [7:0] b, input int d, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (d - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] b, input int d, input logic stop);
    wr(1, REG_BAUD, 4'b0011, d);
    frame(b, d, stop);
    if (stop) begin
      m_ovr   = m_ovr | m_valid;
      m_valid = 1;
      m_byte  = b;
    end else begin
      m_ferr = 1;
    end
  endtask

  task automatic status_clr(input logic [7:0] m);
    wr(1, REG_STATUS, 4'b0001, {24'h0, m});
    if (m[3]) m_valid = 0;
    if (m[4]) m_ovr = 0;
    if (m[5]) m_ferr = 0;
  endtask

  task automatic rx_check(input string nm);
    logic [31:0] v;
    @(negedge clk);
    rd(1, REG_DATA, v);
    chk({nm, "_data"}, v, {23'h0, m_valid, m_byte});
    rd(1, REG_STATUS, v);
    chk({nm, "_flags"}, v & 32'h78, {25'h0, 1'b0, m_ferr, m_ovr, m_valid, 3'b0});
  endtask

  typedef struct {
    logic        s;
    logic [1:0]  wreg;
    logic [3:0]  m;
    logic [31:0] d;
    logic [1:0]  rreg;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  typedef struct {
    logic        s;
    logic [1:0]  r;
    logic [31:0] exp;
    string       nm;
  } rvec_t;

  logic [31:0] reg3_exp;

  initial begin
    rvec_t rv[5];
    vec_t  vt[10];
    logic [31:0] v;
    int w, d, n;
    int dv[5];

`ifdef UART_IRQ_EN
    reg3_exp = 32'h3;
`else
    reg3_exp = 32'h0;
`endif
    rv[0] = '{1, REG_DATA,   32'h0,   "rst_data"};
    rv[1] = '{1, REG_STATUS, 32'h1,   "rst_status"};
    rv[2] = '{1, REG_BAUD,   32'h1B2, "rst_baud"};
    rv[3] = '{1, REG_IRQ_EN, 32'h0,   "rst_reg3"};
    rv[4] = '{0, REG_BAUD,   32'h0,   "rst_nosel"};

    vt[0] = '{1, REG_BAUD,   4'b0011, 32'h0000ABCD, REG_BAUD,   32'hABCD, "baud_both"};
    vt[1] = '{1, REG_BAUD,   4'b0001, 32'h00000012, REG_BAUD,   32'hAB12, "baud_lo"};
    vt[2] = '{1, REG_BAUD,   4'b0010, 32'h00003400, REG_BAUD,   32'h3412, "baud_hi"};
    vt[3] = '{1, REG_BAUD,   4'b1100, 32'hFFFF0000, REG_BAUD,   32'h3412, "baud_uplanes"};
    vt[4] = '{0, REG_BAUD,   4'b0011, 32'h00001111, REG_BAUD,   32'h3412, "baud_nosel"};
    vt[5] = '{1, REG_DATA,   4'b0010, 32'h00005A00, REG_STATUS, 32'h1,    "data_lane1"};
    vt[6] = '{0, REG_DATA,   4'b0001, 32'h0000005A, REG_STATUS, 32'h1,    "data_nosel"};
    vt[7] = '{1, REG_IRQ_EN, 4'b0001, 32'h00000003, REG_IRQ_EN, reg3_exp, "reg3_wr"};
    vt[8] = '{1, REG_IRQ_EN, 4'b0001, 32'h00000000, REG_IRQ_EN, 32'h0,    "reg3_clr"};
    vt[9] = '{1, REG_STATUS, 4'b0001, 32'h0000007F, REG_STATUS, 32'h1,    "status_w1c"};

    repeat (4) @(negedge clk);
    chk("rst_tx_line", 32'(uart_tx), 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rd(rv[i].s, rv[i].r, v);
      chk(rv[i].nm, v, rv[i].exp);
    end

    for (int i = 0; i < 10; i++) begin
      wr(vt[i].s, vt[i].wreg, vt[i].m, vt[i].d);
      rd(1, vt[i].rreg, v);
      chk(vt[i].nm, v, vt[i].exp);
    end

    // Directed 0x55 at div 4, including the busy window
    txq.push_back(8'h55);
    tx_burst(4, w);
    repeat (40) @(negedge clk);
    rd(1, REG_STATUS, v);
    chk("busy_last_cycle", 32'(v[ST_TX_BUSY]), 32'd1);
    @(negedge clk);
    rd(1, REG_STATUS, v);
    chk("busy_after_40", 32'(v[ST_TX_BUSY]), 32'd0);
    check_tx(w, 4);

    // Random back-to-back bursts, including divisor 0
    dv = '{0, 1, 2, 3, 5};
    for (int i = 0; i < 5; i++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
      d = dv[i];
      tx_burst(d, w);
      check_tx(w, d);
      rd(1, REG_STATUS, v);
      chk("tx_idle_status", v, 32'h1);
    end

    // FIFO overflow with a slow line, then reset mid-frame
    txq.push_back(8'hC3);
    tx_burst(16'h1000, w);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 17; k++) txq.push_back(8'(k + 1));
    tx_burst(16'h1000, w);
    txq.delete();
    rd(1, REG_STATUS, v);
    chk("ovf_status", v, 32'h1046);
    status_clr(8'h40);
    rd(1, REG_STATUS, v);
    chk("ovf_cleared", v, 32'h1006);
    chk("tx_in_start", 32'(uart_tx), 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_abort_line", 32'(uart_tx), 32'd1);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    rd(1, REG_STATUS, v);
    chk("rst2_status", v, 32'h1);
    rd(1, REG_BAUD, v);
    chk("rst2_baud", v, 32'h1B2);
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_byte = 0;

    // Directed RX sequence
    rx_send(8'hA3, 8, 1);
    rd(1, REG_DATA, v);
    chk("rx_a3", v, 32'h1A3);
    rx_check("rx_a3m");
    status_clr(8'h08);
    rd(1, REG_DATA, v);
    chk("rx_ack", v, 32'h0A3);
    rx_send(8'h11, 8, 1);
    rx_send(8'h22, 8, 1);
    rd(1, REG_DATA, v);
    chk("rx_ovr_data", v, 32'h122);
    rd(1, REG_STATUS, v);
    chk("rx_ovr_flag", 32'(v[ST_RX_OVR]), 32'd1);
    rx_send(8'h7E, 8, 0);
    rd(1, REG_STATUS, v);
    chk("rx_ferr_flag", 32'(v[ST_RX_FERR]), 32'd1);
    rd(1, REG_DATA, v);
    chk("rx_ferr_data", v, 32'h122);
    status_clr(8'h78);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    rx_check("rx_glitch");

    // Random frames and acknowledges against the byte-level model
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      logic st;
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(8, 14);
      if ($urandom_range(0, 1) == 1) status_clr(8'($urandom) & 8'h38);
      rx_send(b, d, st);
      rx_check($sformatf("rx_rand%0d", i));
    end

`ifdef UART_IRQ_EN
    status_clr(8'h78);
    wr(1, REG_IRQ_EN, 4'b0001, 32'h1);
    fork
      frame(8'h5C, 8, 1);
      begin
        logic [31:0] s;
        bit seen;
        seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          rd(1, REG_STATUS, s);
          if (s[ST_RX_VALID]) seen = 1;
        end
        chk("irq_wait", 32'(seen), 32'd1);
        if (seen) begin
          chk("irq_pre", 32'(irq), 32'd0);
          @(negedge clk);
          chk("irq_set", 32'(irq), 32'd1);
        end
      end
    join
    wr(1, REG_STATUS, 4'b0001, 32'h08);
    @(negedge clk);
    chk("irq_clear", 32'(irq), 32'd0);
    wr(1, REG_IRQ_EN, 4'b0001, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
